spim_avmm_arb: RTL and testbench
================================

# spim_avmm_arb

Two-requester AVMM arbiter in front of the SPI master's AVMM register bridge. It lets the external host AVMM port (requester 0) and an on-die sequencer/BIST AVMM port (requester 1) share the single downstream AVMM target that reaches the command, write-buffer and read-buffer registers. Grants are round-robin and last one full transaction (write accept, or read accept plus read-data return). A read-response timeout guarantees a granted requester can never hang.

## Interface
- RD_TIMEOUT, 64: cycles allowed in read-wait before a synthetic response (2..65535).
- m_avmm_clk  in  1  clock.
- m_avmm_rst_n  in  1  asynchronous, active-low reset.
- rq0_addr / rq1_addr  in  17  requester address.
- rq0_byte_en / rq1_byte_en  in  4  byte enables.
- rq0_write / rq1_write  in  1  write request, held until accepted.
- rq0_read / rq1_read  in  1  read request, held until accepted.
- rq0_wdata / rq1_wdata  in  32  write data.
- rq0_waitreq / rq1_waitreq  out  1  stall to requester.
- rq0_rdata / rq1_rdata  out  32  read data.
- rq0_rdatavld / rq1_rdatavld  out  1  read data valid, 1-cycle pulse.
- dn_addr  out  17  downstream address.
- dn_byte_en  out  4  downstream byte enables.
- dn_write / dn_read  out  1  downstream command.
- dn_wdata  out  32  downstream write data.
- dn_waitreq  in  1  downstream stall.
- dn_rdata  in  32  downstream read data.
- dn_rdatavld  in  1  downstream read data valid.
- err_clr  in  1  clears err_timeout.
- err_timeout  out  1  sticky flag: a read timed out.
- dbg_st  out  8  {3'b0, last_gnt, gnt, cur_st[2:0]}.

## Operation
- States:
  - IDLE (0).
  - GNT_WR (1).
  - GNT_RD (2).
  - RD_WAIT (3).
- Registers:
  - gnt: current owner.
  - last_gnt: previous owner; resets to 1, so requester 0 wins the first tie.
  - 16-bit tmo_cnt.
- IDLE arbitration:
  - Requester x is active if rq_x_write or rq_x_read is asserted.
  - If one requester is active, it is granted.
  - If both are active, the requester != last_gnt is granted.
  - On grant, gnt and last_gnt load the winner.
  - Next state is GNT_WR if the winner's write is asserted (write takes priority when write and read are both asserted), otherwise GNT_RD.
- GNT_WR / GNT_RD:
  - dn_* mirror the granted requester's addr, byte_en and wdata combinationally.
  - dn_write = 1 in GNT_WR only; dn_read = 1 in GNT_RD only.
  - The granted requester's waitreq = dn_waitreq. The other requester's waitreq = 1.
  - GNT_WR: when dn_waitreq = 0, go to IDLE.
  - GNT_RD: when dn_waitreq = 0, clear tmo_cnt and go to RD_WAIT.
  - Abort: if the granted requester drops both write and read, go to IDLE without completing. dn_write and dn_read drop in the same cycle.
- RD_WAIT:
  - dn_read = 0 and both waitreq = 1. tmo_cnt increments every cycle.
  - If dn_rdatavld = 1: rq_gnt_rdata = dn_rdata, rq_gnt_rdatavld = 1 for that cycle, go to IDLE.
  - Else if tmo_cnt == RD_TIMEOUT-1: rq_gnt_rdata = 32'hdead_beef, rq_gnt_rdatavld = 1, err_timeout set, go to IDLE.
- A dn_rdatavld arriving outside RD_WAIT (late response) is dropped and no rdatavld is produced.
- err_timeout:
  - Set on timeout, cleared by err_clr.
  - If set and clear occur in the same cycle, set wins.
- Non-granted outputs:
  - rq_x_rdata = 32'h0 whenever rq_x_rdatavld = 0.
  - In IDLE all dn_* = 0.

## Timing
- Reset values:
  - cur_st = IDLE, gnt = 0, last_gnt = 1, tmo_cnt = 0, err_timeout = 0.
  - dn_write = dn_read = 0; dn_addr, dn_byte_en, dn_wdata = 0.
  - rq0_waitreq = rq1_waitreq = 1; rq0_rdatavld = rq1_rdatavld = 0; rq0_rdata = rq1_rdata = 0.
- Reset is asynchronous. Assertion mid-transaction returns to IDLE immediately and drops dn_write/dn_read. No response is issued for the aborted read.
- Write: request seen at cycle N (IDLE) → dn_write at N+1. With dn_waitreq = 0, rq waitreq is low at N+1, the write is accepted and the state returns to IDLE at N+2.
- Read: request at N → dn_read at N+1, accepted at N+1 → RD_WAIT from N+2. rdatavld is forwarded in the same cycle dn_rdatavld arrives.
- Timeout: with no response, rdatavld/0xdeadbeef pulses at N+1+RD_TIMEOUT.
- Each transaction is followed by a one-cycle IDLE bubble. Back-to-back throughput is 1 write per 2 cycles.
- All requester outputs are combinational from registered state plus dn_* inputs. No combinational path exists from rq inputs to rq waitreq except through the dn_waitreq mux in the grant states.

## Test plan
- Single write, rq0: addr 0x00010, wdata 0xA5A5_1234, dn_waitreq low → dn_write for 1 cycle carries these values; rq0_waitreq low for 1 cycle; rq1_waitreq stays 1.
- Contention: rq0 and rq1 both write every cycle for 8 transactions → grants alternate 0,1,0,1…, rq0 first after reset; each dn_addr matches its owner.
- Read with stall: rq1 reads, dn_waitreq high 3 cycles, dn_rdatavld 5 cycles after accept with dn_rdata 0x1357_9BDF → rq1_rdatavld single pulse with that data; rq0_rdatavld stays 0.
- Timeout, RD_TIMEOUT = 4: rq0 read accepted, no dn_rdatavld → rq0_rdatavld with 0xdead_beef 4 cycles after accept; err_timeout = 1. A later dn_rdatavld is ignored. err_clr clears the flag.
- Write+read both asserted by rq0 → GNT_WR taken, only dn_write asserted.
- Reset asserted in RD_WAIT → all outputs at reset values immediately; subsequent rq1 request is granted first.

Source files
------------

// File: rtl/spim_avmm_arb_if.sv
// ============================================================================
// spim_avmm_arb_if : requester/downstream AVMM bundle around the arbiter
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface spim_avmm_arb_if;
    logic [16:0] rq0_addr;
    logic [3:0]  rq0_byte_en;
    logic        rq0_write;
    logic        rq0_read;
    logic [31:0] rq0_wdata;
    logic        rq0_waitreq;
    logic [31:0] rq0_rdata;
    logic        rq0_rdatavld;

    logic [16:0] rq1_addr;
    logic [3:0]  rq1_byte_en;
    logic        rq1_write;
    logic        rq1_read;
    logic [31:0] rq1_wdata;
    logic        rq1_waitreq;
    logic [31:0] rq1_rdata;
    logic        rq1_rdatavld;

    logic [16:0] dn_addr;
    logic [3:0]  dn_byte_en;
    logic        dn_write;
    logic        dn_read;
    logic [31:0] dn_wdata;
    logic        dn_waitreq;
    logic [31:0] dn_rdata;
    logic        dn_rdatavld;

    logic        err_clr;
    logic        err_timeout;
    logic [7:0]  dbg_st;

    // Arbiter side
    modport slave (
        input  rq0_addr, rq0_byte_en, rq0_write, rq0_read, rq0_wdata,
        output rq0_waitreq, rq0_rdata, rq0_rdatavld,
        input  rq1_addr, rq1_byte_en, rq1_write, rq1_read, rq1_wdata,
        output rq1_waitreq, rq1_rdata, rq1_rdatavld,
        output dn_addr, dn_byte_en, dn_write, dn_read, dn_wdata,
        input  dn_waitreq, dn_rdata, dn_rdatavld,
        input  err_clr,
        output err_timeout, dbg_st
    );

    // Environment side (requesters plus downstream target)
    modport master (
        output rq0_addr, rq0_byte_en, rq0_write, rq0_read, rq0_wdata,
        input  rq0_waitreq, rq0_rdata, rq0_rdatavld,
        output rq1_addr, rq1_byte_en, rq1_write, rq1_read, rq1_wdata,
        input  rq1_waitreq, rq1_rdata, rq1_rdatavld,
        input  dn_addr, dn_byte_en, dn_write, dn_read, dn_wdata,
        output dn_waitreq, dn_rdata, dn_rdatavld,
        output err_clr,
        input  err_timeout, dbg_st
    );
endinterface

`default_nettype wire

// File: rtl/spim_avmm_arb.sv
// ============================================================================
// spim_avmm_arb : round-robin two-requester AVMM arbiter with read timeout
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module spim_avmm_arb #(
    parameter int RD_TIMEOUT = 64
) (
    input  wire logic            m_avmm_clk,
    input  wire logic            m_avmm_rst_n,
    spim_avmm_arb_if.slave       io_bus
);

    localparam logic [2:0]  c_ST_IDLE    = 3'd0;
    localparam logic [2:0]  c_ST_GNT_WR  = 3'd1;
    localparam logic [2:0]  c_ST_GNT_RD  = 3'd2;
    localparam logic [2:0]  c_ST_RD_WAIT = 3'd3;
    localparam logic [15:0] c_TMO_LAST   = 16'(RD_TIMEOUT - 1);
    localparam logic [31:0] c_TMO_DATA   = 32'hdead_beef;

    logic [2:0]  r_st;
    logic [2:0]  w_st_nxt;
    logic        r_gnt;
    logic        r_last_gnt;
    logic [15:0] r_tmo_cnt;
    logic        r_err_timeout;

    logic        w_act0;
    logic        w_act1;
    logic        w_win;
    logic        w_win_wr;
    logic        w_gnt_wr;
    logic        w_gnt_rd;
    logic        w_gnt_act;
    logic        w_tmo_hit;
    logic        w_rd_accept;

    logic [16:0] w_dn_addr;
    logic [3:0]  w_dn_byte_en;
    logic [31:0] w_dn_wdata;
    logic        w_dn_write;
    logic        w_dn_read;
    logic        w_rq0_waitreq;
    logic        w_rq1_waitreq;
    logic        w_rsp_vld;
    logic [31:0] w_rsp_data;

    assign w_act0    = io_bus.rq0_write | io_bus.rq0_read;
    assign w_act1    = io_bus.rq1_write | io_bus.rq1_read;
    // On a tie the requester that did not own the bus last time wins
    assign w_win     = (w_act0 && w_act1) ? ~r_last_gnt : w_act1;
    assign w_win_wr  = w_win ? io_bus.rq1_write : io_bus.rq0_write;

    assign w_gnt_wr  = r_gnt ? io_bus.rq1_write : io_bus.rq0_write;
    assign w_gnt_rd  = r_gnt ? io_bus.rq1_read  : io_bus.rq0_read;
    assign w_gnt_act = w_gnt_wr | w_gnt_rd;

    assign w_tmo_hit   = (r_st == c_ST_RD_WAIT) && !io_bus.dn_rdatavld &&
                         (r_tmo_cnt == c_TMO_LAST);
    assign w_rd_accept = (r_st == c_ST_GNT_RD) && w_gnt_act && !io_bus.dn_waitreq;

    // State register
    always_ff @(posedge m_avmm_clk or negedge m_avmm_rst_n) begin
        if (!m_avmm_rst_n) begin
            r_st <= c_ST_IDLE;
        end else begin
            r_st <= w_st_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_st_nxt = r_st;
        case (r_st)
            c_ST_IDLE: begin
                if (w_act0 || w_act1) begin
                    w_st_nxt = w_win_wr ? c_ST_GNT_WR : c_ST_GNT_RD;
                end
            end
            c_ST_GNT_WR: begin
                if (!w_gnt_act || !io_bus.dn_waitreq) begin
                    w_st_nxt = c_ST_IDLE;
                end
            end
            c_ST_GNT_RD: begin
                if (!w_gnt_act) begin
                    w_st_nxt = c_ST_IDLE;
                end else if (!io_bus.dn_waitreq) begin
                    w_st_nxt = c_ST_RD_WAIT;
                end
            end
            c_ST_RD_WAIT: begin
                if (io_bus.dn_rdatavld || w_tmo_hit) begin
                    w_st_nxt = c_ST_IDLE;
                end
            end
            default: w_st_nxt = c_ST_IDLE;
        endcase
    end

    // Grant ownership, timeout counter and sticky error flag
    always_ff @(posedge m_avmm_clk or negedge m_avmm_rst_n) begin
        if (!m_avmm_rst_n) begin
            r_gnt         <= 1'b0;
            r_last_gnt    <= 1'b1;
            r_tmo_cnt     <= 16'd0;
            r_err_timeout <= 1'b0;
        end else begin
            if ((r_st == c_ST_IDLE) && (w_act0 || w_act1)) begin
                r_gnt      <= w_win;
                r_last_gnt <= w_win;
            end

            if (w_rd_accept) begin
                r_tmo_cnt <= 16'd0;
            end else if (r_st == c_ST_RD_WAIT) begin
                r_tmo_cnt <= r_tmo_cnt + 16'd1;
            end

            if (w_tmo_hit) begin
                r_err_timeout <= 1'b1;
            end else if (io_bus.err_clr) begin
                r_err_timeout <= 1'b0;
            end
        end
    end

    // Output logic
    always_comb begin
        w_dn_addr     = 17'd0;
        w_dn_byte_en  = 4'd0;
        w_dn_wdata    = 32'd0;
        w_dn_write    = 1'b0;
        w_dn_read     = 1'b0;
        w_rq0_waitreq = 1'b1;
        w_rq1_waitreq = 1'b1;
        w_rsp_vld     = 1'b0;
        w_rsp_data    = 32'd0;
        case (r_st)
            c_ST_GNT_WR, c_ST_GNT_RD: begin
                w_dn_addr    = r_gnt ? io_bus.rq1_addr    : io_bus.rq0_addr;
                w_dn_byte_en = r_gnt ? io_bus.rq1_byte_en : io_bus.rq0_byte_en;
                w_dn_wdata   = r_gnt ? io_bus.rq1_wdata   : io_bus.rq0_wdata;
                // An owner that withdraws its request drops the command at once
                w_dn_write   = (r_st == c_ST_GNT_WR) && w_gnt_act;
                w_dn_read    = (r_st == c_ST_GNT_RD) && w_gnt_act;
                if (r_gnt) begin
                    w_rq1_waitreq = io_bus.dn_waitreq;
                end else begin
                    w_rq0_waitreq = io_bus.dn_waitreq;
                end
            end
            c_ST_RD_WAIT: begin
                if (io_bus.dn_rdatavld) begin
                    w_rsp_vld  = 1'b1;
                    w_rsp_data = io_bus.dn_rdata;
                end else if (w_tmo_hit) begin
                    w_rsp_vld  = 1'b1;
                    w_rsp_data = c_TMO_DATA;
                end
            end
            default: begin
                w_dn_write = 1'b0;
            end
        endcase
    end

    assign io_bus.dn_addr      = w_dn_addr;
    assign io_bus.dn_byte_en   = w_dn_byte_en;
    assign io_bus.dn_wdata     = w_dn_wdata;
    assign io_bus.dn_write     = w_dn_write;
    assign io_bus.dn_read      = w_dn_read;
    assign io_bus.rq0_waitreq  = w_rq0_waitreq;
    assign io_bus.rq1_waitreq  = w_rq1_waitreq;
    assign io_bus.rq0_rdatavld = w_rsp_vld && !r_gnt;
    assign io_bus.rq1_rdatavld = w_rsp_vld &&  r_gnt;
    assign io_bus.rq0_rdata    = (w_rsp_vld && !r_gnt) ? w_rsp_data : 32'd0;
    assign io_bus.rq1_rdata    = (w_rsp_vld &&  r_gnt) ? w_rsp_data : 32'd0;
    assign io_bus.err_timeout  = r_err_timeout;
    assign io_bus.dbg_st       = {3'b000, r_last_gnt, r_gnt, r_st};

endmodule

`default_nettype wire

// File: tb/tb_spim_avmm_arb.sv
// ============================================================================
// tb_spim_avmm_arb : directed self-checking bench, default and short timeout
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_spim_avmm_arb;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    spim_avmm_arb_if if_a ();
    spim_avmm_arb_if if_t ();

    spim_avmm_arb #(.RD_TIMEOUT(64)) u_dut (
        .m_avmm_clk   (clk),
        .m_avmm_rst_n (rst_n),
        .io_bus       (if_a)
    );

    spim_avmm_arb #(.RD_TIMEOUT(4)) u_dut_tmo (
        .m_avmm_clk   (clk),
        .m_avmm_rst_n (rst_n),
        .io_bus       (if_t)
    );

    // Short-timeout instance sees exactly the same stimulus
    assign if_t.rq0_addr    = if_a.rq0_addr;
    assign if_t.rq0_byte_en = if_a.rq0_byte_en;
    assign if_t.rq0_write   = if_a.rq0_write;
    assign if_t.rq0_read    = if_a.rq0_read;
    assign if_t.rq0_wdata   = if_a.rq0_wdata;
    assign if_t.rq1_addr    = if_a.rq1_addr;
    assign if_t.rq1_byte_en = if_a.rq1_byte_en;
    assign if_t.rq1_write   = if_a.rq1_write;
    assign if_t.rq1_read    = if_a.rq1_read;
    assign if_t.rq1_wdata   = if_a.rq1_wdata;
    assign if_t.dn_waitreq  = if_a.dn_waitreq;
    assign if_t.dn_rdata    = if_a.dn_rdata;
    assign if_t.dn_rdatavld = if_a.dn_rdatavld;
    assign if_t.err_clr     = if_a.err_clr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    initial begin
        if_a.rq0_addr = '0; if_a.rq0_byte_en = 4'hF; if_a.rq0_write = 1'b0;
        if_a.rq0_read = 1'b0; if_a.rq0_wdata = '0;
        if_a.rq1_addr = '0; if_a.rq1_byte_en = 4'hF; if_a.rq1_write = 1'b0;
        if_a.rq1_read = 1'b0; if_a.rq1_wdata = '0;
        if_a.dn_waitreq = 1'b0; if_a.dn_rdata = '0; if_a.dn_rdatavld = 1'b0;
        if_a.err_clr = 1'b0;

        // Reset state
        nxt();
        chk("rst_wait0", if_a.rq0_waitreq, 1);
        chk("rst_wait1", if_a.rq1_waitreq, 1);
        chk("rst_dnwr",  if_a.dn_write, 0);
        chk("rst_dnrd",  if_a.dn_read, 0);
        chk("rst_addr",  if_a.dn_addr, 0);
        chk("rst_dbg",   if_a.dbg_st, 32'h10);
        chk("rst_err",   if_a.err_timeout, 0);
        chk("rst_vld",   {if_a.rq1_rdatavld, if_a.rq0_rdatavld}, 0);
        rst_n = 1'b1;

        // Contention: both write continuously, grants alternate starting at rq0
        if_a.rq0_write = 1'b1; if_a.rq0_addr = 17'h00100; if_a.rq0_wdata = 32'h1000;
        if_a.rq1_write = 1'b1; if_a.rq1_addr = 17'h00200; if_a.rq1_wdata = 32'h2000;
        for (int i = 0; i < 8; i++) begin
            nxt();
            chk("ctn_dnwr",  if_a.dn_write, 1);
            chk("ctn_addr",  if_a.dn_addr, (i % 2 == 1) ? 32'h200 : 32'h100);
            chk("ctn_wdata", if_a.dn_wdata, (i % 2 == 1) ? 32'h2000 : 32'h1000);
            chk("ctn_wait",  {if_a.rq1_waitreq, if_a.rq0_waitreq}, (i % 2 == 1) ? 32'h1 : 32'h2);
            nxt();
            chk("ctn_bubble", if_a.dn_write, 0);
        end
        if_a.rq0_write = 1'b0; if_a.rq1_write = 1'b0;

        // Single write from rq0
        if_a.rq0_write = 1'b1; if_a.rq0_addr = 17'h00010; if_a.rq0_wdata = 32'hA5A5_1234;
        #1;
        chk("wr_idle", if_a.dn_write, 0);
        nxt();
        chk("wr_dnwr",  if_a.dn_write, 1);
        chk("wr_dnrd",  if_a.dn_read, 0);
        chk("wr_addr",  if_a.dn_addr, 32'h10);
        chk("wr_wdata", if_a.dn_wdata, 32'hA5A5_1234);
        chk("wr_be",    if_a.dn_byte_en, 32'hF);
        chk("wr_wait0", if_a.rq0_waitreq, 0);
        chk("wr_wait1", if_a.rq1_waitreq, 1);
        chk("wr_dbg",   if_a.dbg_st, 32'h01);
        nxt();
        if_a.rq0_write = 1'b0;
        #1;
        chk("wr_done",  if_a.dn_write, 0);
        chk("wr_wait0b", if_a.rq0_waitreq, 1);

        // Write and read asserted together: write wins
        if_a.rq0_write = 1'b1; if_a.rq0_read = 1'b1; if_a.rq0_addr = 17'h00030;
        nxt();
        chk("wrd_dnwr", if_a.dn_write, 1);
        chk("wrd_dnrd", if_a.dn_read, 0);
        chk("wrd_dbg",  if_a.dbg_st, 32'h01);
        nxt();
        if_a.rq0_write = 1'b0; if_a.rq0_read = 1'b0;
        #1;
        chk("wrd_idle", if_a.dbg_st, 32'h00);

        // rq1 read with 3-cycle downstream stall, response 5 cycles after accept
        if_a.rq1_read = 1'b1; if_a.rq1_addr = 17'h00044; if_a.dn_waitreq = 1'b1;
        for (int k = 0; k < 3; k++) begin
            nxt();
            chk("rd_dnrd",  if_a.dn_read, 1);
            chk("rd_addr",  if_a.dn_addr, 32'h44);
            chk("rd_stall", if_a.rq1_waitreq, 1);
            chk("rd_dbg",   if_a.dbg_st, 32'h1A);
        end
        nxt();
        if_a.dn_waitreq = 1'b0;
        #1;
        chk("rd_acc1", if_a.rq1_waitreq, 0);
        chk("rd_acc0", if_a.rq0_waitreq, 1);
        for (int k = 1; k <= 4; k++) begin
            nxt();
            if (k == 1) if_a.rq1_read = 1'b0;
            chk("rd_wait_dnrd", if_a.dn_read, 0);
            chk("rd_wait_vld",  if_a.rq1_rdatavld, 0);
            chk("rd_wait_wr1",  if_a.rq1_waitreq, 1);
            if (k == 4) begin
                chk("t_rd_tmo_vld",  if_t.rq1_rdatavld, 1);
                chk("t_rd_tmo_data", if_t.rq1_rdata, 32'hdead_beef);
            end
        end
        nxt();
        if_a.dn_rdatavld = 1'b1; if_a.dn_rdata = 32'h1357_9BDF;
        #1;
        chk("rd_vld1",  if_a.rq1_rdatavld, 1);
        chk("rd_data1", if_a.rq1_rdata, 32'h1357_9BDF);
        chk("rd_vld0",  if_a.rq0_rdatavld, 0);
        chk("rd_data0", if_a.rq0_rdata, 0);
        chk("t_late_drop", if_t.rq1_rdatavld, 0);
        nxt();
        if_a.dn_rdatavld = 1'b0; if_a.dn_rdata = '0;
        #1;
        chk("rd_vld_end", if_a.rq1_rdatavld, 0);
        chk("rd_dbg_end", if_a.dbg_st, 32'h18);
        chk("t_err_set",  if_t.err_timeout, 1);
        if_a.err_clr = 1'b1;
        nxt();
        if_a.err_clr = 1'b0;
        #1;
        chk("t_err_clr", if_t.err_timeout, 0);

        // rq0 read on the short-timeout instance, no response
        if_a.rq0_read = 1'b1; if_a.rq0_addr = 17'h00080;
        nxt();
        chk("tmo_dnrd",  if_t.dn_read, 1);
        chk("tmo_acc",   if_t.rq0_waitreq, 0);
        nxt();
        if_a.rq0_read = 1'b0;
        for (int k = 2; k <= 4; k++) begin
            if (k > 2) nxt();
            chk("tmo_novld", if_t.rq0_rdatavld, 0);
        end
        nxt();
        chk("tmo_vld",   if_t.rq0_rdatavld, 1);
        chk("tmo_data",  if_t.rq0_rdata, 32'hdead_beef);
        chk("tmo_err0",  if_t.err_timeout, 0);
        chk("tmo_a_vld", if_a.rq0_rdatavld, 0);
        nxt();
        chk("tmo_err1",  if_t.err_timeout, 1);
        chk("tmo_vld0",  if_t.rq0_rdatavld, 0);
        if_a.dn_rdatavld = 1'b1; if_a.dn_rdata = 32'h2468_ACE0;
        #1;
        chk("late_vld",   if_t.rq0_rdatavld, 0);
        chk("late_data",  if_t.rq0_rdata, 0);
        chk("a_rsp_vld",  if_a.rq0_rdatavld, 1);
        chk("a_rsp_data", if_a.rq0_rdata, 32'h2468_ACE0);
        nxt();
        if_a.dn_rdatavld = 1'b0; if_a.dn_rdata = '0; if_a.err_clr = 1'b1;
        #1;
        chk("clr_pend", if_t.err_timeout, 1);
        nxt();
        if_a.err_clr = 1'b0;
        #1;
        chk("clr_done", if_t.err_timeout, 0);

        // Asynchronous reset while rq1 sits in read-wait
        if_a.rq1_read = 1'b1; if_a.rq1_addr = 17'h00099;
        nxt();
        chk("rr_acc", if_a.rq1_waitreq, 0);
        nxt();
        if_a.rq1_read = 1'b0;
        #1;
        chk("rr_dbg_wait", if_a.dbg_st, 32'h1B);
        rst_n = 1'b0;
        #1;
        chk("rr_dbg",   if_a.dbg_st, 32'h10);
        chk("rr_wait",  {if_a.rq1_waitreq, if_a.rq0_waitreq}, 32'h3);
        chk("rr_dnrd",  if_a.dn_read, 0);
        if_a.dn_rdatavld = 1'b1; if_a.dn_rdata = 32'h1111_1111;
        #1;
        chk("rr_novld", if_a.rq1_rdatavld, 0);
        chk("rr_nodat", if_a.rq1_rdata, 0);
        nxt();
        if_a.dn_rdatavld = 1'b0; if_a.dn_rdata = '0;
        rst_n = 1'b1;
        if_a.rq1_write = 1'b1; if_a.rq1_addr = 17'h00055; if_a.rq1_wdata = 32'h5555;
        nxt();
        chk("pr_dnwr",  if_a.dn_write, 1);
        chk("pr_addr",  if_a.dn_addr, 32'h55);
        chk("pr_dbg",   if_a.dbg_st, 32'h19);
        chk("pr_wait",  {if_a.rq1_waitreq, if_a.rq0_waitreq}, 32'h1);
        nxt();
        if_a.rq1_write = 1'b0;
        #1;
        chk("pr_idle",  if_a.dn_write, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
